dcache_direct_mapped: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the core's MEM/WB data port and main memory.

---
 rtl/dcache_direct_mapped.sv | 190 +++++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM/WB data port.
// Misses stall the core while whole lines move over a word-serial req/ack memory port.
module dcache_direct_mapped #(
   parameter int LINE_WORDS_LOG2 = 2,
   parameter int SET_LOG2        = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        rd_req,
   input  logic [3:0]  wr_be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        miss,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;
   localparam int SETS       = 1 << SET_LOG2;
   localparam int IDX_LSB    = 2 + LINE_WORDS_LOG2;
   localparam int TAG_LSB    = 2 + LINE_WORDS_LOG2 + SET_LOG2;
   localparam int TAG_W      = 32 - TAG_LSB;
   localparam logic [LINE_WORDS_LOG2-1:0] CNT_ZERO = {LINE_WORDS_LOG2{1'b0}};
   localparam logic [LINE_WORDS_LOG2-1:0] CNT_LAST = {LINE_WORDS_LOG2{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2
   } stateT;

   stateT stateR, stateNextS;
   logic [LINE_WORDS_LOG2-1:0] cntR, cntNextS, cntIncS;
   logic [SETS-1:0]  validR, dirtyR;
   logic [31:0]      dataArr [SETS*LINE_WORDS];
   logic [TAG_W-1:0] tagArr  [SETS];

   logic [LINE_WORDS_LOG2-1:0] offS;
   logic [SET_LOG2-1:0]        idxS;
   logic [TAG_W-1:0]           tagS;
   logic accessS, storeS, hitS, lastS;
   logic rdHitS, wrHitS, fillWrS, fillDoneS, hitIncS, missIncS;
   logic memReqNextS, memWeNextS;
   logic [31:0] memAddrNextS, memWdataNextS;
   logic [1:0]  unusedByteBits;

   assign offS    = addr[IDX_LSB-1:2];
   assign idxS    = addr[TAG_LSB-1:IDX_LSB];
   assign tagS    = addr[31:TAG_LSB];
   assign unusedByteBits = addr[1:0];
   assign storeS  = |wr_be;
   assign accessS = rd_req | storeS;
   assign hitS    = validR[idxS] & (tagArr[idxS] == tagS);
   assign lastS   = (cntR == CNT_LAST);
   assign cntIncS = cntR + LINE_WORDS_LOG2'(1);
   assign miss    = (stateR != IDLE) | (accessS & ~hitS);

   // Next-state, word counter and next values of the registered memory port
   always_comb begin
      stateNextS    = stateR;
      cntNextS      = cntR;
      memReqNextS   = mem_req;
      memWeNextS    = mem_we;
      memAddrNextS  = mem_addr;
      memWdataNextS = mem_wdata;
      rdHitS        = 1'b0;
      wrHitS        = 1'b0;
      fillWrS       = 1'b0;
      fillDoneS     = 1'b0;
      hitIncS       = 1'b0;
      missIncS      = 1'b0;
      case (stateR)
         IDLE: begin
            if (accessS && hitS) begin
               hitIncS = 1'b1;
               if (storeS) begin
                  wrHitS = 1'b1;
               end else begin
                  rdHitS = 1'b1;
               end
            end else if (accessS) begin
               missIncS    = 1'b1;
               cntNextS    = CNT_ZERO;
               memReqNextS = 1'b1;
               if (validR[idxS] && dirtyR[idxS]) begin
                  stateNextS    = WB;
                  memWeNextS    = 1'b1;
                  memAddrNextS  = {tagArr[idxS], idxS, CNT_ZERO, 2'b00};
                  memWdataNextS = dataArr[{idxS, CNT_ZERO}];
               end else begin
                  stateNextS   = FILL;
                  memWeNextS   = 1'b0;
                  memAddrNextS = {tagS, idxS, CNT_ZERO, 2'b00};
               end
            end else begin
               stateNextS = IDLE;
            end
         end
         WB: begin
            if (mem_ack && lastS) begin
               stateNextS   = FILL;
               cntNextS     = CNT_ZERO;
               memWeNextS   = 1'b0;
               memAddrNextS = {tagS, idxS, CNT_ZERO, 2'b00};
            end else if (mem_ack) begin
               cntNextS      = cntIncS;
               memAddrNextS  = {tagArr[idxS], idxS, cntIncS, 2'b00};
               memWdataNextS = dataArr[{idxS, cntIncS}];
            end else begin
               stateNextS = WB;
            end
         end
         FILL: begin
            if (mem_ack) begin
               fillWrS = 1'b1;
               if (lastS) begin
                  fillDoneS   = 1'b1;
                  stateNextS  = IDLE;
                  cntNextS    = CNT_ZERO;
                  memReqNextS = 1'b0;
               end else begin
                  cntNextS     = cntIncS;
                  memAddrNextS = {tagS, idxS, cntIncS, 2'b00};
               end
            end else begin
               stateNextS = FILL;
            end
         end
         default: begin
            stateNextS  = IDLE;
            cntNextS    = CNT_ZERO;
            memReqNextS = 1'b0;
         end
      endcase
   end

   // Control state, line status bits, memory port, load data and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateR    <= IDLE;
         cntR      <= CNT_ZERO;
         validR    <= {SETS{1'b0}};
         dirtyR    <= {SETS{1'b0}};
         rdata     <= 32'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         hit_cnt   <= 32'd0;
         miss_cnt  <= 32'd0;
      end else begin
         stateR    <= stateNextS;
         cntR      <= cntNextS;
         mem_req   <= memReqNextS;
         mem_we    <= memWeNextS;
         mem_addr  <= memAddrNextS;
         mem_wdata <= memWdataNextS;
         if (rdHitS) rdata <= dataArr[{idxS, offS}];
         if (hitIncS) hit_cnt <= hit_cnt + 32'd1;
         if (missIncS) miss_cnt <= miss_cnt + 32'd1;
         if (wrHitS) dirtyR[idxS] <= 1'b1;
         // The line is invalid from miss detection until its last word lands
         if (missIncS) validR[idxS] <= 1'b0;
         if (fillDoneS) begin
            validR[idxS] <= 1'b1;
            dirtyR[idxS] <= 1'b0;
         end
      end
   end

   // Data and tag arrays: store-hit byte merge, refill words, tag update
   always_ff @(posedge clk) begin
      if (wrHitS) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) dataArr[{idxS, offS}][8*b +: 8] <= wdata[8*b +: 8];
         end
      end else if (fillWrS) begin
         dataArr[{idxS, cntR}] <= mem_rdata;
      end
      if (fillDoneS) tagArr[idxS] <= tagS;
   end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped: a word memory that remembers write-backs
// and acks after a programmable number of wait cycles.
module tb_dcache_direct_mapped;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata, hit_cnt, miss_cnt;
   logic        rd_req, miss, mem_req, mem_we, mem_ack;
   logic [3:0]  wr_be;

   int total = 0;
   int bad   = 0;
   int ackDelay = 1;
   int waitCnt  = 0;
   bit stabOn   = 1'b0;
   bit prevWait = 1'b0;
   logic [31:0] prevAddr;

   logic [31:0] memStore [logic [31:0]];
   logic [31:0] logAddr [64];
   logic [31:0] logData [64];
   logic        logWe   [64];
   int logN = 0;

   dcache_direct_mapped dut (
      .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_be(wr_be), .wdata(wdata),
      .rdata(rdata), .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (memStore.exists(a)) return memStore[a];
      else return 32'hA5A5_0000 | {16'h0000, a[15:0]};
   endfunction

   // Memory responder: decides mem_ack for the next rising edge, logs every word transfer
   always @(negedge clk) begin
      if (mem_req === 1'b1 && mem_ack !== 1'b1) begin
         if (stabOn && prevWait) begin
            check("wait_addr_stable", mem_addr, prevAddr);
            check("wait_miss_high", {31'd0, miss}, 32'd1);
         end
         if (waitCnt == ackDelay) begin
            mem_ack   = 1'b1;
            mem_rdata = memRead(mem_addr);
            if (mem_we) memStore[mem_addr] = mem_wdata;
            if (logN < 64) begin
               logAddr[logN] = mem_addr;
               logData[logN] = mem_wdata;
               logWe[logN]   = mem_we;
            end
            logN++;
            waitCnt  = 0;
            prevWait = 1'b0;
         end else begin
            waitCnt++;
            prevWait = 1'b1;
            prevAddr = mem_addr;
         end
      end else begin
         mem_ack  = 1'b0;
         waitCnt  = 0;
         prevWait = 1'b0;
      end
   end

   task automatic waitNoMiss(input string tag);
      int n = 0;
      while (miss === 1'b1 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_stall_bounded"}, {31'd0, miss}, 32'd0);
   endtask

   task automatic doRead(input logic [31:0] a, input logic [31:0] expData, input string tag);
      addr = a; rd_req = 1'b1; wr_be = 4'h0;
      #1;
      waitNoMiss(tag);
      @(posedge clk); #1;
      rd_req = 1'b0;
      check({tag, "_rdata"}, rdata, expData);
   endtask

   task automatic checkLine(input int first, input logic we, input logic [31:0] base, input string tag);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_addr%0d", tag, i), logAddr[first+i], base + 32'(4*i));
         check($sformatf("%s_we%0d", tag, i), {31'd0, logWe[first+i]}, {31'd0, we});
      end
   endtask

   initial begin
      rst = 1'b1; addr = 32'd0; rd_req = 1'b0; wr_be = 4'h0; wdata = 32'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdata", rdata, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_miss", {31'd0, miss}, 32'd0);
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_miss_cnt", miss_cnt, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: cold read miss, clean refill
      logN = 0;
      addr = 32'h10; rd_req = 1'b1;
      #1;
      check("t1_miss_detect", {31'd0, miss}, 32'd1);
      doRead(32'h10, 32'hA5A5_0010, "t1");
      check("t1_xfers", 32'(logN), 32'd4);
      checkLine(0, 1'b0, 32'h10, "t1");
      check("t1_miss_cnt", miss_cnt, 32'd1);
      check("t1_hit_cnt", hit_cnt, 32'd1);

      // 2: store hit merges two low bytes, read-back next cycle
      logN = 0;
      addr = 32'h14; wr_be = 4'b0011; wdata = 32'h1234_5678;
      #1;
      check("t2_store_miss", {31'd0, miss}, 32'd0);
      @(posedge clk); #1;
      wr_be = 4'h0;
      check("t2_no_mem_req", {31'd0, mem_req}, 32'd0);
      doRead(32'h14, 32'hA5A5_5678, "t2");
      check("t2_xfers", 32'(logN), 32'd0);
      check("t2_hit_cnt", hit_cnt, 32'd3);

      // 3: conflicting tag evicts the dirty line before refilling
      logN = 0;
      doRead(32'h110, 32'hA5A5_0110, "t3");
      check("t3_xfers", 32'(logN), 32'd8);
      checkLine(0, 1'b1, 32'h10, "t3_wb");
      checkLine(4, 1'b0, 32'h110, "t3_fill");
      check("t3_wb_d0", logData[0], 32'hA5A5_0010);
      check("t3_wb_d1", logData[1], 32'hA5A5_5678);
      check("t3_wb_d3", logData[3], 32'hA5A5_001C);
      check("t3_miss_cnt", miss_cnt, 32'd2);

      // 4: clean victim, refill returns the previously written-back word
      logN = 0;
      doRead(32'h14, 32'hA5A5_5678, "t4");
      check("t4_xfers", 32'(logN), 32'd4);
      checkLine(0, 1'b0, 32'h10, "t4");
      check("t4_miss_cnt", miss_cnt, 32'd3);

      // 5: slow memory, read miss then store miss (write-allocate)
      ackDelay = 5; stabOn = 1'b1;
      logN = 0;
      doRead(32'h220, 32'hA5A5_0220, "t5_rd");
      check("t5_rd_xfers", 32'(logN), 32'd4);
      checkLine(0, 1'b0, 32'h220, "t5_rd");
      logN = 0;
      addr = 32'h330; wr_be = 4'hF; wdata = 32'hDEAD_BEEF;
      #1;
      waitNoMiss("t5_st");
      @(posedge clk); #1;
      wr_be = 4'h0;
      check("t5_st_xfers", 32'(logN), 32'd4);
      doRead(32'h330, 32'hDEAD_BEEF, "t5_st");
      check("t5_miss_cnt", miss_cnt, 32'd5);
      check("t5_hit_cnt", hit_cnt, 32'd8);
      stabOn = 1'b0; ackDelay = 1;

      // 6: reset in the middle of a refill
      logN = 0;
      addr = 32'h410; rd_req = 1'b1;
      for (int n = 0; n < 100 && logN < 2; n++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      check("t6_mid_fill_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1; rd_req = 1'b0;
      #1;
      check("t6_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("t6_rst_miss", {31'd0, miss}, 32'd0);
      check("t6_rst_hit_cnt", hit_cnt, 32'd0);
      check("t6_rst_miss_cnt", miss_cnt, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      logN = 0;
      doRead(32'h10, 32'hA5A5_0010, "t6");
      check("t6_xfers", 32'(logN), 32'd4);
      checkLine(0, 1'b0, 32'h10, "t6");
      check("t6_miss_cnt", miss_cnt, 32'd1);
      check("t6_hit_cnt", hit_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
